// File: rtl/demux1ne2_16bit_buffered_if.sv
// Handshake bundle for the 1-to-2 buffered demux: one producer-side input
// stream and two consumer-side output channels, each with an occupancy level.
interface demux1ne2_16bit_buffered_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] hyrja;
  logic             s;
  logic             hyrja_valid;
  logic             hyrja_ready;

  logic [WIDTH-1:0] dalja0;
  logic             valid0;
  logic             ready0;
  logic [LW-1:0]    niveli0;

  logic [WIDTH-1:0] dalja1;
  logic             valid1;
  logic             ready1;
  logic [LW-1:0]    niveli1;

  // The environment side: producer plus both consumers.
  modport master (
    output hyrja, s, hyrja_valid, ready0, ready1,
    input  hyrja_ready, dalja0, valid0, niveli0, dalja1, valid1, niveli1
  );

  // The demux itself.
  modport slave (
    input  hyrja, s, hyrja_valid, ready0, ready1,
    output hyrja_ready, dalja0, valid0, niveli0, dalja1, valid1, niveli1
  );
endinterface

// File: rtl/demux1ne2_16bit_buffered.sv
// 1-to-2 steering block: each accepted input word goes to the FIFO of the
// channel named by s, so a stalled consumer never blocks or corrupts the other.
module demux1ne2_16bit_buffered #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  demux1ne2_16bit_buffered_if.slave      bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [PW-1:0]    wr_ptr [2];
  logic [PW-1:0]    rd_ptr [2];
  logic [LW-1:0]    level  [2];

  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       ready_n;
  logic [WIDTH-1:0] head   [2];

  assign ready_n = {bus.ready1, bus.ready0};

  // Acceptance looks only at the selected channel, so a full channel never
  // stalls words headed for the other one.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      full[ch]  = (level[ch] == LEVEL_FULL);
      empty[ch] = (level[ch] == '0);
      pop[ch]   = !empty[ch] && ready_n[ch];
    end
    bus.hyrja_ready = bus.s ? !full[1] : !full[0];
    push[0] = bus.hyrja_valid && bus.hyrja_ready && !bus.s;
    push[1] = bus.hyrja_valid && bus.hyrja_ready &&  bus.s;
  end

  // NOTE: only pointers and levels are reset; the data array is not, because
  // the empty flag masks it from the outputs and resetting it would cost a
  // reset fan-out to every storage bit for no observable difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        wr_ptr[ch] <= '0;
        rd_ptr[ch] <= '0;
        level[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (push[ch]) wr_ptr[ch] <= wr_ptr[ch] + 1'b1;
        if (pop[ch])  rd_ptr[ch] <= rd_ptr[ch] + 1'b1;
        case ({push[ch], pop[ch]})
          2'b10:   level[ch] <= level[ch] + 1'b1;
          2'b01:   level[ch] <= level[ch] - 1'b1;
          default: level[ch] <= level[ch];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (push[ch]) mem[ch][wr_ptr[ch]] <= bus.hyrja;
    end
  end

  // Head data is forced to zero when empty so stale storage never leaks out.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      head[ch] = empty[ch] ? '0 : mem[ch][rd_ptr[ch]];
    end
  end

  assign bus.dalja0  = head[0];
  assign bus.valid0  = !empty[0];
  assign bus.niveli0 = level[0];
  assign bus.dalja1  = head[1];
  assign bus.valid1  = !empty[1];
  assign bus.niveli1 = level[1];

endmodule

// File: tb/tb_demux1ne2_16bit_buffered.sv
// Bench for the buffered 1-to-2 demux: table of per-cycle vectors with hand
// derived levels, plus a per-channel queue scoreboard for data and order.
module tb_demux1ne2_16bit_buffered;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux1ne2_16bit_buffered_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux1ne2_16bit_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic             valid;
    logic             s;
    logic [WIDTH-1:0] data;
    logic             r0;
    logic             r1;
    logic             exp_ready;  // before the edge
    int               exp_n0;     // after the edge
    int               exp_n1;
  } vec_t;

  vec_t tbl[$];
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic s, input logic [WIDTH-1:0] data,
                              input logic r0, input logic r1, input logic exp_ready,
                              input int exp_n0, input int exp_n1);
    vec_t v;
    v.valid = valid; v.s = s; v.data = data; v.r0 = r0; v.r1 = r1;
    v.exp_ready = exp_ready; v.exp_n0 = exp_n0; v.exp_n1 = exp_n1;
    return v;
  endfunction

  // Called just after a rising edge; drives one cycle and checks both sides of it.
  task automatic apply(input vec_t v, input string tag);
    logic model_ready;
    bus.hyrja_valid = v.valid;
    bus.s           = v.s;
    bus.hyrja       = v.data;
    bus.ready0      = v.r0;
    bus.ready1      = v.r1;
    #3;
    model_ready = v.s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    check({tag, " hyrja_ready"}, 32'(bus.hyrja_ready), 32'(v.exp_ready));
    check({tag, " model_ready"}, 32'(bus.hyrja_ready), 32'(model_ready));
    check({tag, " valid0"}, 32'(bus.valid0), 32'(q0.size() != 0));
    check({tag, " dalja0"}, 32'(bus.dalja0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
    check({tag, " valid1"}, 32'(bus.valid1), 32'(q1.size() != 0));
    check({tag, " dalja1"}, 32'(bus.dalja1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
    @(posedge clk);
    if (v.r0 && q0.size() != 0) void'(q0.pop_front());
    if (v.r1 && q1.size() != 0) void'(q1.pop_front());
    if (v.valid && model_ready) begin
      if (v.s) q1.push_back(v.data);
      else     q0.push_back(v.data);
    end
    #1;
    check({tag, " niveli0"}, 32'(bus.niveli0), 32'(v.exp_n0));
    check({tag, " niveli1"}, 32'(bus.niveli1), 32'(v.exp_n1));
    check({tag, " model_n0"}, 32'(bus.niveli0), 32'(q0.size()));
    check({tag, " model_n1"}, 32'(bus.niveli1), 32'(q1.size()));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Steering, then fill/backpressure/drain, then idle pop on empty.
    tbl.push_back(mk(1, 0, 16'd5,   0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 16'd20,  0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 16'hFFFF,0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 16'h0,   1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'd1,   0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 16'd2,   0, 0, 1, 2, 0));
    tbl.push_back(mk(1, 0, 16'd3,   0, 0, 0, 2, 0));  // held: channel 0 full
    tbl.push_back(mk(1, 1, 16'd3,   0, 0, 1, 2, 1));  // lands in channel 1
    tbl.push_back(mk(1, 0, 16'd77,  1, 0, 0, 1, 1));  // full blocks push even with ready0
    tbl.push_back(mk(0, 0, 16'h0,   1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0,   1, 1, 1, 0, 0));  // pops on empty do nothing
    // Stream 100..107 with continuous pop: level settles at 1, pointers wrap.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 0, WIDTH'(100 + i), 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 16'd200, 1, 0, 1, 0, 1));  // pop ch0 while pushing ch1
    tbl.push_back(mk(0, 0, 16'h0,   0, 1, 1, 0, 0));

    // Reset held with a valid word presented.
    bus.hyrja_valid = 1'b1;
    bus.s           = 1'b0;
    bus.hyrja       = 16'hABCD;
    bus.ready0      = 1'b0;
    bus.ready1      = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst valid0",  32'(bus.valid0),  32'd0);
    check("rst valid1",  32'(bus.valid1),  32'd0);
    check("rst niveli0", 32'(bus.niveli0), 32'd0);
    check("rst niveli1", 32'(bus.niveli1), 32'd0);
    check("rst dalja0",  32'(bus.dalja0),  32'd0);
    check("rst dalja1",  32'(bus.dalja1),  32'd0);
    bus.hyrja_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst hyrja_ready", 32'(bus.hyrja_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Async reset between edges with data in both channels.
    apply(mk(1, 0, 16'h11, 0, 0, 1, 1, 0), "ar0");
    apply(mk(1, 1, 16'h22, 0, 0, 1, 1, 1), "ar1");
    bus.hyrja_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async valid0",  32'(bus.valid0),  32'd0);
    check("async valid1",  32'(bus.valid1),  32'd0);
    check("async niveli0", 32'(bus.niveli0), 32'd0);
    check("async niveli1", 32'(bus.niveli1), 32'd0);
    check("async dalja0",  32'(bus.dalja0),  32'd0);
    check("async dalja1",  32'(bus.dalja1),  32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(1, 1, 16'd9, 0, 0, 1, 0, 1), "after-rst push");
    check("after-rst dalja1", 32'(bus.dalja1), 32'd9);
    check("after-rst valid1", 32'(bus.valid1), 32'd1);
    apply(mk(0, 0, 16'h0, 0, 1, 1, 0, 0), "after-rst drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux1ne2_16bit_buffered.md
Name: demux1ne2_16bit_buffered

Overview:
- 1-to-2 steering block: the reverse direction of the 2-to-1 16-bit select mux.
- Takes one 16-bit input stream with a valid/ready handshake and routes each word to one of two output channels, chosen per word by a select bit.
- Each output channel has its own small FIFO, so one stalled consumer does not corrupt the other channel's data.
- Sits between a producer (e.g. write-back/result path) and two independent consumers in the 16-bit datapath.

Parameters:
- WIDTH, 16, data width of input and both outputs.
- DEPTH, 2, entries per output FIFO; power of 2, minimum 2.

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Hyrja  input  WIDTH  input data word.
- S  input  1  destination select: 0 -> channel 0, 1 -> channel 1; sampled with Hyrja.
- HyrjaValid  input  1  producer presents a valid word.
- HyrjaReady  output  1  block can accept the word to the channel currently selected by S.
- Dalja0  output  WIDTH  channel 0 head-of-FIFO data.
- Valid0  output  1  channel 0 FIFO non-empty.
- Ready0  input  1  channel 0 consumer accepts the head word.
- Niveli0  output  clog2(DEPTH)+1  channel 0 occupancy.
- Dalja1  output  WIDTH  channel 1 head-of-FIFO data.
- Valid1  output  1  channel 1 FIFO non-empty.
- Ready1  input  1  channel 1 consumer accepts the head word.
- Niveli1  output  clog2(DEPTH)+1  channel 1 occupancy.

Behaviour:
- Reset (Reset_n=0, asynchronous, any time including mid-transfer):
  - Both FIFOs emptied; pointers and Niveli0/1 go to 0.
  - Valid0/1=0; Dalja0/1=0.
  - HyrjaReady reflects the empty FIFOs (1) once reset is released.
  - Stored data is discarded, not recovered.
- HyrjaReady:
  - Combinational.
  - S=0: HyrjaReady = !(Niveli0==DEPTH).
  - S=1: HyrjaReady = !(Niveli1==DEPTH).
  - Independent of HyrjaValid and of Ready0/Ready1; no bypass when full.
- Push: HyrjaValid && HyrjaReady at a rising edge writes Hyrja into the FIFO of channel S. Exactly one channel is written per accepted word.
- Pop: ValidN && ReadyN at a rising edge removes the channel N head word.
- Latency:
  - A word accepted at edge k into an empty FIFO drives DaljaN, with ValidN=1, right after edge k, i.e. one cycle later.
  - DaljaN is combinational from FIFO head storage.
- Empty channel: ValidN=0, DaljaN=0. A ReadyN asserted while empty has no effect.
- Full channel (NiveliN==DEPTH):
  - Pushes to it are blocked even if ReadyN=1 in the same cycle.
  - The other channel still accepts.
- Simultaneous push and pop on the same non-full, non-empty channel: NiveliN is unchanged, and order is preserved (FIFO).
- Simultaneous push to one channel and pop from the other: both happen, each NiveliN updates independently.
- Both channels may pop in the same cycle.
- Pointers wrap modulo DEPTH. NiveliN never exceeds DEPTH and never underflows.
- Order: per-channel FIFO order is strict. No ordering guarantee across channels.
- HyrjaValid=0: no state change from the input side. S and Hyrja are don't-care.

Test Plan:
1. Reset check: hold Reset_n=0 with HyrjaValid=1 -> Valid0=Valid1=0, Niveli0=Niveli1=0, Dalja0=Dalja1=0. Release -> HyrjaReady=1.
2. Basic steering, with Ready0=Ready1=0:
   - Push Hyrja=5, S=0, then Hyrja=20, S=1.
   - Next cycle: Dalja0=5, Valid0=1, Niveli0=1, Dalja1=20, Valid1=1, Niveli1=1.
3. Full/backpressure, DEPTH=2, Ready0=0:
   - Push 1, 2 to channel 0 -> Niveli0=2, HyrjaReady=0 with S=0.
   - Third word 3 held; switch S=1 -> HyrjaReady=1, word 3 lands in channel 1.
4. Drain order: Ready0=1 on full channel 0 holding 1, 2 -> Dalja0 reads 1 then 2, then Valid0=0, Dalja0=0, Niveli0=0.
5. Wrap and simultaneous push/pop: stream 100..107 to channel 0 with Ready0=1 every cycle -> Niveli0 stays 1 in steady state, outputs 100..107 in order, pointers wrap.
6. Async reset mid-stream: assert Reset_n low between clock edges with both FIFOs holding data -> all outputs clear immediately, without waiting for a clock edge. After release, new word 9 to channel 1 appears with Niveli1=1.
